// File: rtl/alu_decoder_pkg.sv
// alu_decoder_pkg: instruction field positions, class/form/write-mask encodings and the registered decode record
package alu_decoder_pkg;
  localparam int CLASS_MSB = 31;
  localparam int CLASS_LSB = 29;
  localparam int CONST_BIT = 28;
  localparam int FORM_BIT  = 27;
  localparam int OP_MSB    = 26;
  localparam int OP_LSB    = 24;
  localparam int VEC_MSB   = 23;
  localparam int VEC_LSB   = 22;
  localparam int RSV_MSB   = 21;
  localparam int RSV_LSB   = 20;
  localparam int ZR_MSB    = 19;
  localparam int ZR_LSB    = 16;
  localparam logic [2:0] CLASS_ALU = 3'b000;
  localparam logic FORM4 = 1'b0;
  localparam logic FORM3 = 1'b1;
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_Y1   = 2'b01;
  localparam logic [1:0] W_BOTH = 2'b11;
  typedef struct packed {
    logic        invalid;
    logic [2:0]  op;
    logic [1:0]  vec;
    logic        form;
    logic        const_c;
    logic [31:0] constant;
    logic [3:0]  zero_reg;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic [3:0]  d;
    logic [3:0]  y1;
    logic [3:0]  y2;
    logic [1:0]  write;
  } dec_t;
endpackage

// File: rtl/alu_instr_decoder_if.sv
// alu_instr_decoder_if: instruction word in (master drives) and registered decode fields out (slave drives)
interface alu_instr_decoder_if;
  logic [31:0] instruction;
  logic        invalid_instruction;
  logic [2:0]  alu_op;
  logic [1:0]  alu_vec_perci;
  logic        alu_form;
  logic        const_c;
  logic [31:0] constant;
  logic [3:0]  zero_reg;
  logic [3:0]  alu_a_select;
  logic [3:0]  alu_b_select;
  logic [3:0]  alu_c_select;
  logic [3:0]  alu_d_select;
  logic [3:0]  alu_Y1_select;
  logic [3:0]  alu_Y2_select;
  logic [1:0]  alu_write;
  modport master (
    output instruction,
    input  invalid_instruction, alu_op, alu_vec_perci, alu_form, const_c, constant, zero_reg,
           alu_a_select, alu_b_select, alu_c_select, alu_d_select, alu_Y1_select, alu_Y2_select, alu_write
  );
  modport slave (
    input  instruction,
    output invalid_instruction, alu_op, alu_vec_perci, alu_form, const_c, constant, zero_reg,
           alu_a_select, alu_b_select, alu_c_select, alu_d_select, alu_Y1_select, alu_Y2_select, alu_write
  );
endinterface

// File: rtl/alu_const_extend.sv
// alu_const_extend: 12-bit immediate imm to 32-bit ext; sign-extends when ALU_DECODER_CONST_SEXT_EN is defined, else zero-extends
module alu_const_extend (
  input  logic [11:0] imm,
  output logic [31:0] ext
);
`ifdef ALU_DECODER_CONST_SEXT_EN
  assign ext = {{20{imm[11]}}, imm};
`else
  assign ext = {20'b0, imm};
`endif
endmodule

// File: rtl/alu_instr_decoder.sv
// alu_instr_decoder: clk, rst (sync active-high), bus (slave: instruction in, decode fields out, 1-cycle latency); constant extension set by ALU_DECODER_CONST_SEXT_EN
module alu_instr_decoder
  import alu_decoder_pkg::*;
(
  input logic clk,
  input logic rst,
  alu_instr_decoder_if.slave bus
);
  logic [31:0] ins;
  logic [31:0] ext;
  logic        f4, f3, bad;
  dec_t        dec_d, dec_q;
  assign ins = bus.instruction;
  assign f4  = !ins[CONST_BIT] && ins[FORM_BIT] == FORM4;
  assign f3  = !ins[CONST_BIT] && ins[FORM_BIT] == FORM3;
  assign bad = ins[CLASS_MSB:CLASS_LSB] != CLASS_ALU || ins[RSV_MSB:RSV_LSB] != 2'b00 ||
               (ins[CONST_BIT] && ins[FORM_BIT] == FORM3);
  alu_const_extend u_ext (.imm(ins[11:0]), .ext(ext));
  always_comb begin
    dec_d          = '0;
    dec_d.invalid  = bad;
    dec_d.op       = ins[OP_MSB:OP_LSB];
    dec_d.vec      = ins[VEC_MSB:VEC_LSB];
    dec_d.form     = ins[FORM_BIT];
    dec_d.const_c  = ins[CONST_BIT];
    dec_d.zero_reg = ins[ZR_MSB:ZR_LSB];
    dec_d.constant = ins[CONST_BIT] ? ext : 32'd0;
    dec_d.a        = f3 ? ins[11:8] : ins[15:12];
    dec_d.b        = f3 ? ins[7:4] : ins[11:8];
    dec_d.c        = f4 ? ins[7:4] : 4'd0;
    dec_d.d        = f4 ? ins[3:0] : 4'd0;
    dec_d.y1       = ins[15:12];
    dec_d.y2       = f4 ? ins[7:4] : 4'd0;
    dec_d.write    = bad ? W_NONE : (f4 ? W_BOTH : W_Y1);
  end
  always_ff @(posedge clk) dec_q <= rst ? '0 : dec_d;
  assign bus.invalid_instruction = dec_q.invalid;
  assign bus.alu_op              = dec_q.op;
  assign bus.alu_vec_perci       = dec_q.vec;
  assign bus.alu_form            = dec_q.form;
  assign bus.const_c             = dec_q.const_c;
  assign bus.constant            = dec_q.constant;
  assign bus.zero_reg            = dec_q.zero_reg;
  assign bus.alu_a_select        = dec_q.a;
  assign bus.alu_b_select        = dec_q.b;
  assign bus.alu_c_select        = dec_q.c;
  assign bus.alu_d_select        = dec_q.d;
  assign bus.alu_Y1_select       = dec_q.y1;
  assign bus.alu_Y2_select       = dec_q.y2;
  assign bus.alu_write           = dec_q.write;
endmodule

// File: tb/tb_alu_instr_decoder.sv
// tb_alu_instr_decoder: directed scoreboard bench for alu_instr_decoder, hand-computed expectations per instruction
module tb_alu_instr_decoder;
  import alu_decoder_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  dec_t sb[$];
  alu_instr_decoder_if bus ();
  alu_instr_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef ALU_DECODER_CONST_SEXT_EN
  localparam logic [31:0] K800 = 32'hFFFFF800;
  localparam logic [31:0] KA7F = 32'hFFFFFA7F;
`else
  localparam logic [31:0] K800 = 32'h00000800;
  localparam logic [31:0] KA7F = 32'h00000A7F;
`endif
  function automatic dec_t mk(logic inv, logic [2:0] op, logic [1:0] vec, logic form, logic cc,
                              logic [31:0] k, logic [3:0] zr, logic [3:0] a, logic [3:0] b,
                              logic [3:0] c, logic [3:0] d, logic [3:0] y1, logic [3:0] y2,
                              logic [1:0] w);
    return '{invalid: inv, op: op, vec: vec, form: form, const_c: cc, constant: k, zero_reg: zr,
             a: a, b: b, c: c, d: d, y1: y1, y2: y2, write: w};
  endfunction
  task automatic step(string tag, logic r, logic [31:0] instr, dec_t e);
    dec_t obs, exp_v;
    @(negedge clk);
    rst = r;
    bus.instruction = instr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs = '{invalid: bus.invalid_instruction, op: bus.alu_op, vec: bus.alu_vec_perci,
            form: bus.alu_form, const_c: bus.const_c, constant: bus.constant,
            zero_reg: bus.zero_reg, a: bus.alu_a_select, b: bus.alu_b_select,
            c: bus.alu_c_select, d: bus.alu_d_select, y1: bus.alu_Y1_select,
            y2: bus.alu_Y2_select, write: bus.alu_write};
    exp_v = sb.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  initial begin
    bus.instruction = 32'hFFFFFFFF;
    step("reset0", 1'b1, 32'hFFFFFFFF, '0);
    step("reset1", 1'b1, 32'hFFFFFFFF, '0);
    step("reg4",    1'b0, 32'h00801234, mk(0, 3'd0, 2'b10, 0, 0, 32'd0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h3, 2'b11));
    step("const800",1'b0, 32'h10801800, mk(0, 3'd0, 2'b10, 0, 1, K800,  4'h0, 4'h1, 4'h8, 4'h0, 4'h0, 4'h1, 4'h0, 2'b01));
    step("rsv_bad", 1'b0, 32'h01180100, mk(1, 3'd1, 2'b00, 0, 0, 32'd0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00));
    step("const3f", 1'b0, 32'h18801234, mk(1, 3'd0, 2'b10, 1, 1, 32'h234, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 2'b00));
    step("reg3",    1'b0, 32'h08801234, mk(0, 3'd0, 2'b10, 1, 0, 32'd0, 4'h0, 4'h2, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 2'b01));
    step("class_bad",1'b0,32'h20801234, mk(1, 3'd0, 2'b10, 0, 0, 32'd0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h3, 2'b00));
    step("constA7F",1'b0, 32'h17CF5A7F, mk(0, 3'd7, 2'b11, 0, 1, KA7F,  4'hF, 4'h5, 4'hA, 4'h0, 4'h0, 4'h5, 4'h0, 2'b01));
    step("rsv11",   1'b0, 32'h06B98765, mk(1, 3'd6, 2'b10, 0, 0, 32'd0, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h8, 4'h6, 2'b00));
    step("reg3_hi", 1'b0, 32'h0D4EFEDC, mk(0, 3'd5, 2'b01, 1, 0, 32'd0, 4'hE, 4'hE, 4'hD, 4'h0, 4'h0, 4'hF, 4'h0, 2'b01));
    step("rst_prio",1'b1, 32'h00801234, '0);
    step("const0",  1'b0, 32'h10000000, mk(0, 3'd0, 2'b00, 0, 1, 32'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01));
    step("reg4_b2b",1'b0, 32'h00801234, mk(0, 3'd0, 2'b10, 0, 0, 32'd0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h3, 2'b11));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_instr_decoder.md
# alu_instr_decoder

Decodes one 32-bit ALU-class instruction word into the control fields that drive the ALU datapath: operation, vector/carry mode, operand and result register selects, write enables and an optional immediate constant. It sits between instruction fetch and the ALU/register-file, and flags any malformed encoding so the pipeline can suppress it. All outputs are registered, one cycle behind the instruction.

## Interface
- No parameters.
- Clocking is fixed: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 32: instruction word, sampled every cycle.
- `invalid_instruction` out 1: encoding violates the format rules.
- `alu_op` out 3: ALU operation, taken from instr[26:24].
- `alu_vec_perci` out 2: vector/carry mode, taken from instr[23:22].
- `alu_form` out 1: instr[27]; 0 = 4-operand form, 1 = 3-operand form.
- `const_c` out 1: instr[28]; immediate-constant form.
- `constant` out 32: extended immediate.
- `zero_reg` out 4: instr[19:16]; per-operand force-zero mask, bit0 = a … bit3 = d.
- `alu_a_select`, `alu_b_select`, `alu_c_select`, `alu_d_select` out 4 each: operand register selects.
- `alu_Y1_select`, `alu_Y2_select` out 4 each: result register selects.
- `alu_write` out 2: bit0 writes Y1, bit1 writes Y2.

## Operation
- Field layout:
  - [31:29] class, must be 000.
  - [28] const_c.
  - [27] form.
  - [26:24] op.
  - [23:22] vec_perci.
  - [21:20] reserved, must be 00.
  - [19:16] zero_reg.
  - [15:0] operand nibbles N3..N0.
- 4-form register (const=0, form=0):
  - a=N3, b=N2, c=N1, d=N0.
  - Y1=N3, Y2=N1.
  - write=11.
  - constant=0.
- 3-form register (const=0, form=1):
  - Y1=N3, a=N2, b=N1, c=d=0.
  - Y2=0.
  - write=01.
  - constant=0.
- Constant form (const=1, form=0):
  - a=Y1=N3, b=N2.
  - c=d=Y2=0.
  - write=01.
  - constant = instr[11:0], extended per Configuration.
- Invalid when any of:
  - class ≠ 000;
  - reserved ≠ 00;
  - const=1 together with form=1.
- On an invalid instruction:
  - invalid_instruction=1 and write=00.
  - All other fields still decode as above.
- op, vec_perci, form, const_c and zero_reg pass through unmodified in every case.

## Timing
- Decode is combinational; all outputs are registered on the rising edge of clk. Latency is 1 cycle.
- No handshake. A new instruction is accepted every cycle.
- While rst=1 at an edge, every output is cleared to 0, including invalid_instruction and alu_write.
- The first decode after reset appears on the edge following rst deassertion.
- Reset takes priority over the instruction being sampled on the same edge.

## Configuration
- `ALU_DECODER_CONST_SEXT_EN`
  - Defined: constant = sign-extended instr[11:0], so 0x800 → 0xFFFFF800.
  - Undefined (default): zero-extended, so 0x800 → 2048.

## Structure
- A shared package `alu_decoder_pkg` holds:
  - field bit-position localparams;
  - class value 000;
  - form encodings: FORM4=0, FORM3=1;
  - write-mask constants: W_NONE=00, W_Y1=01, W_BOTH=11.
- One natural sub-module, `alu_const_extend`: 12-bit to 32-bit extender, macro-controlled.
- The register stage lives in the top module.

## Test plan
- Reset: assert rst for 2 cycles with 0xFFFFFFFF applied -> every output 0.
- 0x00801234 -> one cycle later:
  - op=000, vec=10, form=0, const=0, constant=0, zero_reg=0;
  - a/b/c/d = 1/2/3/4, Y1=1, Y2=3;
  - write=11, invalid=0.
- 0x10801800, no macro -> one cycle later:
  - const=1, constant=2048;
  - a=1, b=8, c=d=0, Y1=1, Y2=0;
  - write=01, invalid=0.
- 0x01180100 (reserved bits set) -> one cycle later: invalid=1, write=00, op=001, zero_reg=1000.
- 0x18801234 (const with 3-form) -> invalid=1, write=00.
- 0x08801234 (3-form register) -> Y1=1, a=2, b=3, c=d=Y2=0, write=01.
- Same constant instruction with `ALU_DECODER_CONST_SEXT_EN` defined -> constant=0xFFFFF800.
